// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit serializer.
//               The PARITY state exists only when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_parity_calc.sv
// ============================================================================
// Module      : uart_parity_calc
// Description : Even/odd parity bit for one data word (used under
//               UART_TX_PARITY_EN only).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             parity_type,
  output logic             parity_bit
);

  assign parity_bit = (parity_type == PARITY_EVEN) ? (^data) : (~^data);

endmodule

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART frame serializer (start, data LSB first, optional parity,
//               stop). Parity is compiled in with macro UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid_in,
  input  logic             parity_type_in,
  output logic             tx_out,
  output logic             busy_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_tx;
  logic             r_busy;
  logic             w_tx_next;
  logic             w_accept;
  logic             w_last_bit;

  assign w_accept   = (r_state == IDLE) && data_valid_in;
  assign w_last_bit = (r_bit_cnt == C_LAST_BIT);

`ifdef UART_TX_PARITY_EN
  logic r_parity_type;
  logic w_parity_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity_type <= PARITY_EVEN;
    end else if (w_accept) begin
      r_parity_type <= parity_type_in;
    end
  end

  uart_parity_calc #(
    .WIDTH(WIDTH)
  ) u_parity_calc (
    .data       (r_data),
    .parity_type(r_parity_type),
    .parity_bit (w_parity_bit)
  );
`else
  logic w_unused_parity_type;
  assign w_unused_parity_type = parity_type_in;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (data_valid_in) begin
          w_state_next = START;
        end
      end
      START: begin
        w_state_next = DATA;
      end
      DATA: begin
        if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_state_next = STOP;
      end
`endif
      STOP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Data is captured only on acceptance, so requests mid-frame cannot disturb it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (w_accept) begin
      r_data <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= '0;
    end else if (r_state == START) begin
      r_bit_cnt <= '0;
    end else if ((r_state == DATA) && !w_last_bit) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_data[r_bit_cnt];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = w_parity_bit;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  // Outputs trail the state by one cycle, giving the one-cycle start latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= (r_state != IDLE);
    end
  end

  assign tx_out   = r_tx;
  assign busy_out = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Scoreboard bench for uart_tx_serializer; adapts frame length
//               to UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_serializer;

  localparam int WIDTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 3;
`else
  localparam int FRAME_LEN = WIDTH + 2;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             data_valid_in = 1'b0;
  logic             parity_type_in = 1'b0;
  logic             tx_out;
  logic             busy_out;

  uart_tx_serializer #(
    .WIDTH(WIDTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .parity_type_in(parity_type_in),
    .tx_out        (tx_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  typedef struct {
    logic [7:0] d;
    logic       ptype;
    logic       par;
  } vec_t;

  frame_t exp_q[$];
  int     gap_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit i of bits is the i-th serial bit on the line; par is hand-computed.
  function automatic frame_t mk_frame(input logic [7:0] d, input logic par);
    frame_t f;
`ifdef UART_TX_PARITY_EN
    f.bits = {5'b0, 1'b1, par, d, 1'b0};
    f.len  = 11;
`else
    logic par_unused;
    par_unused = par;
    f.bits = {6'b0, 1'b1, d, 1'b0};
    f.len  = 10;
`endif
    return f;
  endfunction

  // Monitor: pops one expected frame per busy period and checks every bit.
  initial begin
    frame_t cur;
    int     idx = 0;
    int     idle_run = 0;
    bit     in_frame = 1'b0;
    bit     rogue = 1'b0;
    cur.bits = '0;
    cur.len  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_frame = 1'b0;
        idle_run = 0;
      end else if (busy_out === 1'b1) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          idx      = 0;
          gap_q.push_back(idle_run);
          idle_run = 0;
          if (exp_q.size() == 0) begin
            rogue = 1'b1;
            chk("unexpected_frame_busy", {31'b0, busy_out}, 32'd0);
          end else begin
            rogue = 1'b0;
            cur   = exp_q.pop_front();
          end
        end
        if (!rogue && idx < cur.len)
          chk($sformatf("frame_bit%0d", idx), {31'b0, tx_out}, {31'b0, cur.bits[idx]});
        idx++;
      end else begin
        if (in_frame) begin
          if (!rogue) chk("busy_length", idx, cur.len);
          in_frame = 1'b0;
        end
        chk("idle_level", {31'b0, tx_out}, 32'd1);
        idle_run++;
      end
    end
  end

  // Called at posedge+2; accept happens on the next edge.
  task automatic send(input logic [7:0] d, input logic ptype, input logic par);
    exp_q.push_back(mk_frame(d, par));
    data_in        = d;
    parity_type_in = ptype;
    data_valid_in  = 1'b1;
    @(posedge clk); #1;
    chk("accept_cycle_busy", {31'b0, busy_out}, 32'd0);
    chk("accept_cycle_tx", {31'b0, tx_out}, 32'd1);
    data_valid_in  = 1'b0;
    data_in        = ~d;
    parity_type_in = ~ptype;
    @(posedge clk); #1;
    chk("start_busy", {31'b0, busy_out}, 32'd1);
    chk("start_tx", {31'b0, tx_out}, 32'd0);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || busy_out !== 1'b0) && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("done_timeout_busy", {31'b0, busy_out}, 32'd0);
    @(posedge clk); #2;
  endtask

  vec_t vecs[6] = '{
    '{8'h3C, 1'b0, 1'b0},
    '{8'hA5, 1'b0, 1'b0},
    '{8'h01, 1'b1, 1'b0},
    '{8'h00, 1'b1, 1'b1},
    '{8'hFF, 1'b1, 1'b1},
    '{8'h80, 1'b0, 1'b1}
  };

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("reset_tx_async", {31'b0, tx_out}, 32'd1);
    chk("reset_busy_async", {31'b0, busy_out}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tx_held", {31'b0, tx_out}, 32'd1);
    reset_n = 1'b1;

    // First request lands on the first edge after reset release.
    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].ptype, vecs[i].par);
      wait_done();
    end

    // Request mid-frame must be ignored.
    send(8'h55, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    data_in       = 8'hFF;
    data_valid_in = 1'b1;
    @(posedge clk); #2;
    data_valid_in = 1'b0;
    wait_done();
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("no_second_frame_busy", {31'b0, busy_out}, 32'd0);
    end
    #1;

    // Continuous valid: three frames with one idle cycle between each.
    gap_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk_frame(8'h81, 1'b0));
    data_in        = 8'h81;
    parity_type_in = 1'b0;
    data_valid_in  = 1'b1;
    repeat (2 * (FRAME_LEN + 1) + 1) @(posedge clk);
    #2;
    data_valid_in = 1'b0;
    wait_done();
    chk("gap_count", gap_q.size(), 32'd3);
    if (gap_q.size() >= 3) begin
      chk("gap_1", gap_q[1], 32'd1);
      chk("gap_2", gap_q[2], 32'd1);
    end

    // Reset during DATA aborts immediately and does not resume.
    send(8'h3C, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midframe_reset_tx", {31'b0, tx_out}, 32'd1);
    chk("midframe_reset_busy", {31'b0, busy_out}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("post_reset_busy", {31'b0, busy_out}, 32'd0);
      chk("post_reset_tx", {31'b0, tx_out}, 32'd1);
    end
    #1;
    send(8'hA5, 1'b0, 1'b0);
    wait_done();

    repeat (3) @(posedge clk);
    chk("frames_left", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of data bits per frame.
REQ-002 SHALL have port clk, input, 1 bit: bit-rate clock; one serial bit per cycle.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port data_in, input, WIDTH bits: byte to transmit; the upstream control block drives it.
REQ-005 SHALL have port data_valid_in, input, 1 bit: single-cycle request to send data_in.
REQ-006 SHALL have port parity_type_in, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-007 SHALL have port tx_out, output, 1 bit: serial line; idle level is 1.
REQ-008 SHALL have port busy_out, output, 1 bit: a frame is in progress; the upstream block consumes it as its tx-busy input.

Function
REQ-009 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-010 In IDLE with data_valid_in=1, SHALL latch data_in and parity_type_in and go to START on the next edge.
REQ-011 SHALL ignore data_valid_in in every state other than IDLE; no queueing, and the latched data SHALL NOT change.
REQ-012 START SHALL drive tx_out=0 for exactly 1 cycle, then go to DATA.
REQ-013 DATA SHALL drive the latched bits LSB first, 1 cycle each, for WIDTH cycles.
REQ-014 DATA SHALL use a bit counter of width $clog2(WIDTH) that clears on entry to DATA.
REQ-015 On the last DATA bit, SHALL go to PARITY if parity is compiled in, otherwise to STOP.
REQ-016 PARITY SHALL drive ^data when even, or ~^data when odd, computed from the latched data, for 1 cycle.
REQ-017 STOP SHALL drive tx_out=1 for 1 cycle, then go to IDLE.
REQ-018 tx_out and busy_out SHALL be registered outputs with no combinational path from any input.
REQ-019 With acceptance at edge n, the start bit SHALL appear after edge n+1 (latency 1 cycle).
REQ-020 busy_out SHALL be 1 from the start-bit cycle through the stop-bit cycle inclusive, and 0 in IDLE.
REQ-021 With data_valid_in held at 1 continuously, frames SHALL be separated by exactly one idle cycle (tx_out=1, busy_out=0).
REQ-022 In IDLE, tx_out SHALL be 1.

Reset
REQ-023 While reset_n=0, SHALL force state=IDLE, tx_out=1, busy_out=0, bit counter=0 and latched data=0, asynchronously.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately and SHALL NOT resume it after release.
REQ-025 SHALL accept a new request on the first edge after reset_n rises.

Configuration
REQ-026 Macro UART_TX_PARITY_EN SHALL control the parity feature.
REQ-027 With UART_TX_PARITY_EN defined, the frame SHALL be start + WIDTH data + parity + stop, i.e. WIDTH+3 cycles busy.
REQ-028 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, parity_type_in SHALL be ignored, and the frame SHALL be WIDTH+2 cycles busy.
REQ-029 The port list SHALL be identical with and without UART_TX_PARITY_EN.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum typedef and the parity constants PARITY_EVEN=0 and PARITY_ODD=1.
REQ-031 Parity SHALL be computed in sub-module uart_parity_calc (inputs: data, type; output: bit), instantiated only under UART_TX_PARITY_EN.
REQ-032 The FSM, bit counter and output registers SHALL reside in uart_tx_serializer.

Verification
REQ-033 Parity on, send 0xA5 with even parity -> tx_out 0,1,0,1,0,0,1,0,1,0,1; busy_out=1 for 11 cycles.
REQ-034 Parity on, send 0x01 with odd parity -> parity bit 0; send 0x00 with odd parity -> parity bit 1.
REQ-035 Parity off, send 0x3C -> tx_out 0,0,0,1,1,1,1,0,0,1; busy_out=1 for 10 cycles.
REQ-036 Send 0x55, then pulse data_valid_in with 0xFF at cycle 4 of the frame -> only 0x55 is sent; tx_out stays 1 afterwards.
REQ-037 Hold data_valid_in=1 with 0x81 -> back-to-back frames with exactly one idle cycle between them.
REQ-038 Assert reset_n=0 during the DATA state -> tx_out=1 and busy_out=0 without waiting for a clock edge; no residual bits after release.
